// File: rtl/gpio_pkg.sv
// gpio_pkg: shared encodings and sizing for the GPIO port pin datapath
package gpio_pkg;

    localparam int PIN_NUM = 16;

    typedef enum logic [1:0] {
        MODE_IN  = 2'b00,
        MODE_OUT = 2'b01,
        MODE_AF  = 2'b10,
        MODE_AN  = 2'b11
    } gpio_mode_e;

    typedef enum logic [1:0] {
        TRIG_RISE = 2'b00,
        TRIG_FALL = 2'b01,
        TRIG_BOTH = 2'b10,
        TRIG_HIGH = 2'b11
    } gpio_trig_e;

    typedef enum logic [1:0] {
        PULL_NONE     = 2'b00,
        PULL_UP       = 2'b01,
        PULL_DOWN     = 2'b10,
        PULL_NONE_ALT = 2'b11
    } gpio_pull_e;

endpackage

// File: rtl/gpio_port_core_pin_ctrl.sv
// gpio_pin_ctrl: one pin's input synchroniser, interrupt status, toggle state and pad mux
module gpio_pin_ctrl
    import gpio_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] mode,
    input  logic       od_type,
    input  logic [1:0] pupd,
    input  logic       odata,
    input  logic       toggle,
    input  logic [1:0] af_sel,
    input  logic [3:0] af_out,
    input  logic [3:0] af_oe,
    input  logic [1:0] trig,
    input  logic       int_en,
    input  logic       int_clr,
    input  logic       pad_in,
    output logic       idata,
    output logic       sta,
    output logic       pad_out,
    output logic       pad_oe,
    output logic       pad_ie,
    output logic       pad_pu,
    output logic       pad_pd
);

    logic [SYNC_STAGES-1:0] sync;
    logic prev, tglq, tgl_state, evt, data, oe;

    assign pad_ie = mode != MODE_AN;
    assign idata  = sync[SYNC_STAGES-1] & pad_ie;
    assign pad_pu = (pupd == PULL_UP) & pad_ie;
    assign pad_pd = (pupd == PULL_DOWN) & pad_ie;

    // Analog mode suppresses events, including the fall caused by forcing idata low
    assign evt = pad_ie & ((trig == TRIG_RISE) ? idata & ~prev :
                           (trig == TRIG_FALL) ? ~idata & prev :
                           (trig == TRIG_BOTH) ? idata ^ prev : idata);

    assign data = (mode == MODE_OUT) ? odata ^ tgl_state :
                  (mode == MODE_AF)  ? af_out[af_sel] : 1'b0;
    assign oe   = (mode == MODE_OUT) | ((mode == MODE_AF) & af_oe[af_sel]);

    // Open-drain only ever drives low; data is already 0 in input/analog modes
    assign pad_out = data & ~od_type;
    assign pad_oe  = oe & ~(od_type & data);

    // Pad synchroniser and one-cycle-delayed sample for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '0;
            prev <= 1'b0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], pad_in};
            prev <= idata;
        end
    end

    // Sticky status: clear wins over a simultaneous event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sta <= 1'b0;
        else        sta <= int_clr ? 1'b0 : (evt & int_en) ? 1'b1 : sta;
    end

    // Toggle state flips once per rising edge of the toggle request level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tglq      <= 1'b0;
            tgl_state <= 1'b0;
        end else begin
            tglq      <= toggle;
            tgl_state <= tgl_state ^ (toggle & ~tglq);
        end
    end

endmodule

// File: rtl/gpio_port_core.sv
// gpio_port_core: 16-pin GPIO pad datapath fed by the APB register block
module gpio_port_core
    import gpio_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [2*PIN_NUM-1:0] r_modex,
    input  logic [PIN_NUM-1:0]   r_typex,
    input  logic [2*PIN_NUM-1:0] r_speedx,
    input  logic [2*PIN_NUM-1:0] r_pupdx,
    input  logic [PIN_NUM-1:0]   r_odx,
    input  logic [PIN_NUM-1:0]   r_togglex,
    input  logic [2*PIN_NUM-1:0] r_afx,
    input  logic [2*PIN_NUM-1:0] r_inttrigx,
    input  logic [PIN_NUM-1:0]   r_intx_en,
    input  logic [PIN_NUM-1:0]   r_intx_clr,
    output logic [PIN_NUM-1:0]   r_idx,
    output logic [PIN_NUM-1:0]   r_intx_sta,
    input  logic [PIN_NUM-1:0]   gpio_in,
    output logic [PIN_NUM-1:0]   gpio_out,
    output logic [PIN_NUM-1:0]   gpio_oe,
    output logic [PIN_NUM-1:0]   gpio_ie,
    output logic [PIN_NUM-1:0]   gpio_pu,
    output logic [PIN_NUM-1:0]   gpio_pd,
    output logic [2*PIN_NUM-1:0] gpio_ds,
    input  logic [4*PIN_NUM-1:0] af_out,
    input  logic [4*PIN_NUM-1:0] af_oe,
    output logic [PIN_NUM-1:0]   af_in,
    output logic                 gpio_irq
);

    assign gpio_ds = r_speedx;
    assign af_in   = r_idx;

    for (genvar i = 0; i < PIN_NUM; i++) begin : g_pin
        gpio_pin_ctrl #(.SYNC_STAGES(SYNC_STAGES)) u_pin (
            .clk     (clk),
            .rst_n   (rst_n),
            .mode    (r_modex[2*i+:2]),
            .od_type (r_typex[i]),
            .pupd    (r_pupdx[2*i+:2]),
            .odata   (r_odx[i]),
            .toggle  (r_togglex[i]),
            .af_sel  (r_afx[2*i+:2]),
            .af_out  (af_out[4*i+:4]),
            .af_oe   (af_oe[4*i+:4]),
            .trig    (r_inttrigx[2*i+:2]),
            .int_en  (r_intx_en[i]),
            .int_clr (r_intx_clr[i]),
            .pad_in  (gpio_in[i]),
            .idata   (r_idx[i]),
            .sta     (r_intx_sta[i]),
            .pad_out (gpio_out[i]),
            .pad_oe  (gpio_oe[i]),
            .pad_ie  (gpio_ie[i]),
            .pad_pu  (gpio_pu[i]),
            .pad_pd  (gpio_pd[i])
        );
    end

    // Interrupt line is the OR of all status bits, registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) gpio_irq <= 1'b0;
        else        gpio_irq <= |r_intx_sta;
    end

endmodule

// File: tb/tb_gpio_port_core.sv
// tb_gpio_port_core: directed and randomized checks of gpio_port_core against a behavioural model
module tb_gpio_port_core;

    localparam int SYNC = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] r_modex, r_speedx, r_pupdx, r_afx, r_inttrigx;
    logic [15:0] r_typex, r_odx, r_togglex, r_intx_en, r_intx_clr, gpio_in;
    logic [63:0] af_out, af_oe;
    logic [15:0] r_idx, r_intx_sta, gpio_out, gpio_oe, gpio_ie, gpio_pu, gpio_pd, af_in;
    logic [31:0] gpio_ds;
    logic        gpio_irq;

    int checks = 0;
    int errors = 0;

    gpio_port_core #(.SYNC_STAGES(SYNC)) dut (
        .clk(clk), .rst_n(rst_n), .r_modex(r_modex), .r_typex(r_typex), .r_speedx(r_speedx),
        .r_pupdx(r_pupdx), .r_odx(r_odx), .r_togglex(r_togglex), .r_afx(r_afx),
        .r_inttrigx(r_inttrigx), .r_intx_en(r_intx_en), .r_intx_clr(r_intx_clr),
        .r_idx(r_idx), .r_intx_sta(r_intx_sta), .gpio_in(gpio_in), .gpio_out(gpio_out),
        .gpio_oe(gpio_oe), .gpio_ie(gpio_ie), .gpio_pu(gpio_pu), .gpio_pd(gpio_pd),
        .gpio_ds(gpio_ds), .af_out(af_out), .af_oe(af_oe), .af_in(af_in), .gpio_irq(gpio_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Behavioural model: pad samples queue, last observed inputs, sticky status
    bit [15:0] m_q[$];
    bit [15:0] m_prev, m_sta, m_tgl, m_tglq, m_cur;
    bit        m_irq;
    bit [15:0] e_idx, e_out, e_oe, e_ie, e_pu, e_pd;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_q.delete();
            repeat (SYNC) m_q.push_back(16'h0);
            m_prev = 0; m_sta = 0; m_tgl = 0; m_tglq = 0; m_irq = 0;
        end else begin
            for (int i = 0; i < 16; i++) m_cur[i] = m_q[0][i] && (r_modex[2*i+:2] != 2'd3);
            m_irq = |m_sta;
            for (int i = 0; i < 16; i++) begin
                bit ev;
                case (r_inttrigx[2*i+:2])
                    2'd0:    ev = m_cur[i] && !m_prev[i];
                    2'd1:    ev = !m_cur[i] && m_prev[i];
                    2'd2:    ev = m_cur[i] != m_prev[i];
                    default: ev = m_cur[i];
                endcase
                if (r_modex[2*i+:2] == 2'd3) ev = 0;
                if (r_intx_clr[i]) m_sta[i] = 0;
                else if (ev && r_intx_en[i]) m_sta[i] = 1;
                if (r_togglex[i] && !m_tglq[i]) m_tgl[i] = !m_tgl[i];
            end
            m_prev = m_cur;
            m_tglq = r_togglex;
            m_q.push_back(gpio_in);
            void'(m_q.pop_front());
        end
        #1;
        for (int i = 0; i < 16; i++) begin
            bit [1:0] md, sel;
            bit d, o;
            md = r_modex[2*i+:2];
            e_ie[i]  = md != 2'd3;
            e_idx[i] = m_q[0][i] && e_ie[i];
            d = 0; o = 0;
            if (md == 2'd1) begin
                d = r_odx[i] ^ m_tgl[i]; o = 1;
            end else if (md == 2'd2) begin
                sel = r_afx[2*i+:2];
                d = af_out[4*i+sel]; o = af_oe[4*i+sel];
            end
            if (r_typex[i] && (md == 2'd1 || md == 2'd2)) begin
                e_out[i] = 0; e_oe[i] = o && !d;
            end else begin
                e_out[i] = d; e_oe[i] = o;
            end
            e_pu[i] = (r_pupdx[2*i+:2] == 2'd1) && e_ie[i];
            e_pd[i] = (r_pupdx[2*i+:2] == 2'd2) && e_ie[i];
        end
        chk("m_r_idx", r_idx, e_idx);
        chk("m_af_in", af_in, e_idx);
        chk("m_sta", r_intx_sta, m_sta);
        chk("m_irq", gpio_irq, m_irq);
        chk("m_out", gpio_out, e_out);
        chk("m_oe", gpio_oe, e_oe);
        chk("m_ie", gpio_ie, e_ie);
        chk("m_pu", gpio_pu, e_pu);
        chk("m_pd", gpio_pd, e_pd);
        chk("m_ds", gpio_ds, r_speedx);
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst_n = 0; r_modex = '1; r_typex = 0; r_speedx = 32'h1234_5678; r_pupdx = 0;
        r_odx = 0; r_togglex = 0; r_afx = 0; r_inttrigx = 0; r_intx_en = 0; r_intx_clr = 0;
        gpio_in = 0; af_out = 0; af_oe = 0;
        repeat (3) tick();
        chk("rst_idx", r_idx, 0);
        chk("rst_ie", gpio_ie, 0);
        chk("rst_oe", gpio_oe, 0);
        chk("rst_sta", r_intx_sta, 0);
        chk("rst_irq", gpio_irq, 0);
        rst_n = 1; r_modex = 0; r_intx_en = 16'h0008;
        repeat (3) tick();
        // input sync and rising interrupt on pin 3
        gpio_in = 16'h0008;
        tick(); chk("sync_n", r_idx[3], 0);
        tick(); chk("sync_n1", r_idx[3], 1); chk("sta3_early", r_intx_sta[3], 0);
        tick(); chk("sta3_set", r_intx_sta[3], 1); chk("irq_early", gpio_irq, 0);
        tick(); chk("irq_set", gpio_irq, 1);
        gpio_in = 0;
        repeat (4) tick();
        chk("sta3_sticky", r_intx_sta[3], 1);
        // clear priority over a level trigger on pin 0
        r_intx_clr = '1; r_inttrigx = 32'h3; r_intx_en = 16'h0009; gpio_in = 16'h0001;
        repeat (4) tick();
        chk("clr_hold", r_intx_sta, 0);
        r_intx_clr = 0;
        tick(); chk("clr_release", r_intx_sta, 16'h0001);
        // toggle on pin 5
        r_intx_clr = '1; r_modex = 32'h0000_0400; r_odx = 0; r_togglex = 0;
        tick(); chk("tgl_init", gpio_out[5], 0); chk("tgl_oe", gpio_oe[5], 1);
        r_togglex = 16'h0020;
        tick(); chk("tgl_flip", gpio_out[5], 1);
        repeat (9) tick();
        chk("tgl_stable", gpio_out[5], 1);
        r_togglex = 0;
        repeat (2) tick();
        r_togglex = 16'h0020;
        tick(); chk("tgl_flip2", gpio_out[5], 0);
        // open-drain alternate function on pin 7, function 2
        r_modex = 32'h0000_8000; r_typex = 16'h0080; r_afx = 32'h0000_8000;
        af_oe = 64'h1 << 30; af_out = 0;
        #1; chk("od_low_oe", gpio_oe[7], 1); chk("od_low_out", gpio_out[7], 0);
        af_out = 64'h1 << 30;
        #1; chk("od_high_oe", gpio_oe[7], 0); chk("od_high_out", gpio_out[7], 0);
        r_typex = 0;
        #1; chk("pp_out", gpio_out[7], 1); chk("pp_oe", gpio_oe[7], 1);
        // pulls and analog on pin 2
        r_inttrigx = 32'h10; r_intx_en = 16'h0004; gpio_in = 16'h0004; r_modex = 0; r_pupdx = 32'h10;
        repeat (4) tick();
        chk("pu_in", gpio_pu[2], 1); chk("pd_in", gpio_pd[2], 0); chk("idx2_in", r_idx[2], 1);
        r_intx_clr = 0;
        tick(); chk("sta_quiet", r_intx_sta, 0);
        r_modex = 32'h30;
        #1; chk("an_ie", gpio_ie[2], 0); chk("an_pu", gpio_pu[2], 0);
        chk("an_pd", gpio_pd[2], 0); chk("an_idx", r_idx[2], 0);
        repeat (3) tick();
        chk("an_no_evt", r_intx_sta[2], 0); chk("an_no_irq", gpio_irq, 0);
        // randomized traffic with occasional mid-run resets
        r_intx_en = '1;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0) r_modex = $urandom;
            if ($urandom_range(0, 15) == 0) r_inttrigx = $urandom;
            if ($urandom_range(0, 15) == 0) r_typex = $urandom;
            if ($urandom_range(0, 15) == 0) r_pupdx = $urandom;
            if ($urandom_range(0, 15) == 0) r_afx = $urandom;
            if ($urandom_range(0, 15) == 0) r_odx = $urandom;
            if ($urandom_range(0, 15) == 0) r_intx_en = $urandom | $urandom;
            if ($urandom_range(0, 31) == 0) r_speedx = $urandom;
            gpio_in    = gpio_in ^ ($urandom & $urandom & $urandom);
            r_togglex  = r_togglex ^ ($urandom & $urandom & $urandom);
            r_intx_clr = $urandom & $urandom & $urandom & $urandom;
            af_out     = {$urandom, $urandom};
            af_oe      = {$urandom, $urandom};
            if ($urandom_range(0, 299) == 0) begin
                rst_n = 0; r_modex = '1;
                #1; chk("midrst_idx", r_idx, 0); chk("midrst_sta", r_intx_sta, 0);
                chk("midrst_irq", gpio_irq, 0); chk("midrst_oe", gpio_oe, 0);
                chk("midrst_ie", gpio_ie, 0);
                repeat ($urandom_range(1, 3)) tick();
                rst_n = 1;
            end
            tick();
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
